// File: rtl/uart_rom_dumper_pkg.sv
// Shared UART framing constants, dumper FSM encoding and byte-lane helper
// used by the ROM dumper and its serializer.
package uart_rom_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_NEXT  = 3'd4
  } dump_state_e;

  localparam logic START_BIT        = 1'b0;
  localparam logic STOP_BIT         = 1'b1;
  localparam int   DATA_BITS        = 8;
  localparam int   CLKS_PER_BIT_DEF = 434;
  localparam int   BYTES_PER_WORD   = 4;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = word[7:0];
      2'd1:    sel = word[15:8];
      2'd2:    sel = word[23:16];
      2'd3:    sel = word[31:24];
      default: sel = 8'h00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready rises in the final stop-bit cycle so a waiting
// byte follows with no idle bit in between.
module uart_tx_byte
  import uart_rom_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int             CW            = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     IDX_LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0]     IDX_STOP      = 4'(DATA_BITS + 1);

  logic          active_q, active_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready_o = !active_q || ((idx_q == IDX_STOP) && bit_end);
  assign tx_o    = tx_q;

  // Frame sequencing: bit index 0 is start, 1..8 data LSB first, 9 stop.
  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    if (valid_i && ready_o) begin
      active_d = 1'b1;
      idx_d    = 4'd0;
      cnt_d    = '0;
      sh_d     = data_i;
      tx_d     = START_BIT;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (idx_q == IDX_STOP) begin
          active_d = 1'b0;
          tx_d     = STOP_BIT;
        end else begin
          idx_d = idx_q + 4'd1;
          if (idx_q < IDX_LAST_DATA) begin
            tx_d = sh_q[0];
            sh_d = {1'b0, sh_q[7:1]};
          end else begin
            tx_d = STOP_BIT;
          end
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      tx_d = STOP_BIT;
    end
  end

  // State register with synchronous active-low reset; line idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      idx_q    <= 4'd0;
      cnt_q    <= '0;
      sh_q     <= 8'h00;
      tx_q     <= STOP_BIT;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/uart_rom_dumper.sv
// Streams a range of instruction-ROM words out over UART, four bytes per word,
// least significant byte first, so a host can read back a loaded program.
module uart_rom_dumper
  import uart_rom_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_rd,
  output logic             uart_tx,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       BYTE_END = 3'(BYTES_PER_WORD);

  dump_state_e      state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      word_q, word_d;
  logic [2:0]       bidx_q, bidx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(tx_valid),
    .data_i (tx_data),
    .ready_o(tx_ready),
    .tx_o   (uart_tx)
  );

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Dump sequencing; byte 0 is handed over straight from rom_rd in LOAD so the
  // first start bit follows LOAD with no extra cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    word_d      = word_q;
    bidx_d      = bidx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = word_count;
          addr_d      = 32'd0;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        word_d   = rom_rd;
        tx_valid = 1'b1;
        tx_data  = rom_rd[7:0];
        if (tx_ready) begin
          bidx_d  = 3'd1;
          state_d = ST_SEND;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (bidx_q != BYTE_END) begin
          tx_valid = 1'b1;
          tx_data  = word_byte(word_q, bidx_q[1:0]);
          if (tx_ready) begin
            bidx_d = bidx_q + 3'd1;
          end else begin
            bidx_d = bidx_q;
          end
        end else if (tx_ready) begin
          // Ready here marks the last cycle of byte 3's stop bit.
          if (remaining_q == CNT_ONE) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_NEXT: begin
        remaining_d = remaining_q - CNT_ONE;
        addr_d      = addr_q + 32'd1;
        state_d     = ST_FETCH;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      addr_q      <= 32'd0;
      word_q      <= 32'd0;
      bidx_q      <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_rom_dumper.sv
// Directed bench for uart_rom_dumper: records outputs every cycle after a start,
// decodes 8N1 frames and compares against hand-computed streams and timings.
module tb_uart_rom_dumper;

  localparam int C      = 4;
  localparam int MAXLEN = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] word_count;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd;
  logic        uart_tx;
  logic        busy;
  logic        done;

  logic [31:0] rom_mem [0:15];

  int checks = 0;
  int errors = 0;

  logic        tx_log   [0:MAXLEN-1];
  logic        busy_log [0:MAXLEN-1];
  logic        done_log [0:MAXLEN-1];
  logic [31:0] addr_log [0:MAXLEN-1];

  int          nbytes;
  int          frame_err;
  logic [7:0]  byte_val [0:31];
  int          byte_pos [0:31];

  always #5 clk = ~clk;

  assign rom_rd = (rom_addr < 32'd16) ? rom_mem[rom_addr[3:0]] : 32'h0000_0000;

  uart_rom_dumper #(
    .CLKS_PER_BIT(C),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .word_count(word_count),
    .rom_addr  (rom_addr),
    .rom_rd    (rom_rd),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic begin_dump(input logic [15:0] wc);
    @(negedge clk);
    word_count = wc;
    start      = 1'b1;
  endtask

  // Index i holds the outputs seen after the i-th rising edge following the start edge.
  task automatic capture(input int len, input int pulse_a, input int pulse_b,
                         input int rst_at, input logic [15:0] wc_late);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      tx_log[i]   = uart_tx;
      busy_log[i] = busy;
      done_log[i] = done;
      addr_log[i] = rom_addr;
      start       = (i == pulse_a || i == pulse_b) ? 1'b1 : 1'b0;
      rst_n       = (i == rst_at) ? 1'b0 : 1'b1;
      if (i == 3) word_count = wc_late;
    end
  endtask

  task automatic decode(input int from, input int len);
    int         i;
    logic [7:0] b;
    logic       bad;
    nbytes    = 0;
    frame_err = 0;
    i         = from;
    while (i < len) begin
      if (tx_log[i] == 1'b0 && nbytes < 32) begin
        if (i + 10*C > len) begin
          frame_err++;
          i = len;
        end else begin
          bad = 1'b0;
          b   = 8'h00;
          for (int bt = 0; bt < 10; bt++)
            for (int c = 0; c < C; c++)
              if (tx_log[i+bt*C+c] !== tx_log[i+bt*C]) bad = 1'b1;
          if (tx_log[i+9*C] !== 1'b1) bad = 1'b1;
          for (int d = 0; d < 8; d++) b[d] = tx_log[i+(d+1)*C];
          if (bad) frame_err++;
          byte_val[nbytes] = b;
          byte_pos[nbytes] = i;
          nbytes++;
          i += 10*C;
        end
      end else begin
        i++;
      end
    end
  endtask

  function automatic int first_done(input int from, input int len);
    for (int i = from; i < len; i++) if (done_log[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_done(input int len);
    int n = 0;
    for (int i = 0; i < len; i++) if (done_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_busy(input int len);
    int n = 0;
    for (int i = 0; i < len; i++) if (busy_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_low(input int from, input int len);
    int n = 0;
    for (int i = from; i < len; i++) if (tx_log[i] !== 1'b1) n++;
    return n;
  endfunction

  function automatic logic [31:0] word_at(input int w);
    return {byte_val[4*w+3], byte_val[4*w+2], byte_val[4*w+1], byte_val[4*w]};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 32'h0000_0000;
    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = 16'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx",   {31'd0, uart_tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy},    32'd0);
    check_eq("rst_done", {31'd0, done},    32'd0);
    check_eq("rst_addr", rom_addr,         32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word 0xDEADBEEF
    rom_mem[0] = 32'hDEAD_BEEF;
    begin_dump(16'd1);
    capture(200, -1, -1, -1, 16'd7);
    decode(0, 200);
    check_eq("t1_nbytes", nbytes, 32'd4);
    check_eq("t1_framing", frame_err, 32'd0);
    check_eq("t1_word", word_at(0), 32'hDEAD_BEEF);
    check_eq("t1_first_start", byte_pos[0], 32'd2);
    check_eq("t1_last_start", byte_pos[3], 32'd122);
    check_eq("t1_done_at", first_done(0, 200), 32'd162);
    check_eq("t1_done_cnt", count_done(200), 32'd1);
    check_eq("t1_busy_cycles", count_busy(200), 32'd162);
    check_eq("t1_busy_first", {31'd0, busy_log[0]}, 32'd1);

    // Three words, address stepping and inter-word gap
    rom_mem[0] = 32'h0000_0001;
    rom_mem[1] = 32'h8000_0000;
    rom_mem[2] = 32'h1234_5678;
    begin_dump(16'd3);
    capture(520, -1, -1, -1, 16'd7);
    decode(0, 520);
    check_eq("t2_nbytes", nbytes, 32'd12);
    check_eq("t2_framing", frame_err, 32'd0);
    check_eq("t2_word0", word_at(0), 32'h0000_0001);
    check_eq("t2_word1", word_at(1), 32'h8000_0000);
    check_eq("t2_word2", word_at(2), 32'h1234_5678);
    check_eq("t2_word1_start", byte_pos[4], 32'd165);
    check_eq("t2_word2_start", byte_pos[8], 32'd328);
    check_eq("t2_addr0", addr_log[byte_pos[0]], 32'd0);
    check_eq("t2_addr1", addr_log[byte_pos[4]], 32'd1);
    check_eq("t2_addr2", addr_log[byte_pos[8]], 32'd2);
    check_eq("t2_done_at", first_done(0, 520), 32'd488);
    check_eq("t2_done_cnt", count_done(520), 32'd1);

    // Zero-length request
    begin_dump(16'd0);
    capture(20, -1, -1, -1, 16'd0);
    check_eq("t3_tx_low", count_low(0, 20), 32'd0);
    check_eq("t3_busy", count_busy(20), 32'd0);
    check_eq("t3_done_at", first_done(0, 20), 32'd0);
    check_eq("t3_done_cnt", count_done(20), 32'd1);

    // Start pulses while busy are ignored
    rom_mem[0] = 32'hDEAD_BEEF;
    begin_dump(16'd1);
    capture(200, 5, 100, -1, 16'd7);
    decode(0, 200);
    check_eq("t4_nbytes", nbytes, 32'd4);
    check_eq("t4_word", word_at(0), 32'hDEAD_BEEF);
    check_eq("t4_first_start", byte_pos[0], 32'd2);
    check_eq("t4_done_at", first_done(0, 200), 32'd162);
    check_eq("t4_done_cnt", count_done(200), 32'd1);
    check_eq("t4_busy_cycles", count_busy(200), 32'd162);

    // Reset during frame bit 3 of byte 1 of word 1
    rom_mem[1] = 32'hA5C3_0FF0;
    begin_dump(16'd3);
    capture(300, -1, -1, 218, 16'd7);
    check_eq("t5_addr_before", addr_log[218], 32'd1);
    check_eq("t5_tx_after", {31'd0, tx_log[219]}, 32'd1);
    check_eq("t5_busy_after", {31'd0, busy_log[219]}, 32'd0);
    check_eq("t5_addr_after", addr_log[219], 32'd0);
    check_eq("t5_no_resume", count_low(219, 300), 32'd0);
    check_eq("t5_no_done", count_done(300), 32'd0);
    begin_dump(16'd1);
    capture(200, -1, -1, -1, 16'd7);
    decode(0, 200);
    check_eq("t5_re_nbytes", nbytes, 32'd4);
    check_eq("t5_re_framing", frame_err, 32'd0);
    check_eq("t5_re_word", word_at(0), 32'hDEAD_BEEF);
    check_eq("t5_re_done_at", first_done(0, 200), 32'd162);

    // New start in the done cycle
    begin_dump(16'd1);
    capture(360, 162, -1, -1, 16'd1);
    decode(0, 360);
    check_eq("t6_nbytes", nbytes, 32'd8);
    check_eq("t6_framing", frame_err, 32'd0);
    check_eq("t6_word0", word_at(0), 32'hDEAD_BEEF);
    check_eq("t6_word1", word_at(1), 32'hDEAD_BEEF);
    check_eq("t6_second_start", byte_pos[4], 32'd165);
    check_eq("t6_busy_gap", {31'd0, busy_log[162]}, 32'd0);
    check_eq("t6_busy_again", {31'd0, busy_log[163]}, 32'd1);
    check_eq("t6_done2_at", first_done(163, 360), 32'd325);
    check_eq("t6_done_cnt", count_done(360), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
